// File: rtl/get_data_arbiter.sv
// Purpose: round-robin share of one get_data lookup unit between two requesters, with a watchdog on the unit.
// Latency: start sampled at edge k -> mem_start after k+1 -> reqN_valid after k+3; timeout adds TIMEOUT cycles.
// Backpressure: a result is held in RESP until reqN_ready; one outstanding request per requester, extra starts dropped.
//
// Ports:
//   _clock, _reset            single rising-edge clock, asynchronous active-high reset
//   reqN_addr/start/ready     requester N request address, start strobe, result accept
//   reqN_valid/done/err/out0  requester N result (done mirrors valid, err marks a timeout response)
//   reqN_busy                 requester N has a request pending or in flight
//   mem_addr/start/ready      request side of the shared get_data unit
//   mem_valid/done/out0       result side of the shared get_data unit (done is not used)
//   grant                     index of the most recently granted requester
module get_data_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                    _clock,
  input  logic                    _reset,
  input  logic signed [WIDTH-1:0] req0_addr,
  input  logic                    req0_start,
  input  logic                    req0_ready,
  output logic                    req0_valid,
  output logic                    req0_done,
  output logic                    req0_err,
  output logic                    req0_busy,
  output logic signed [WIDTH-1:0] req0_out0,
  input  logic signed [WIDTH-1:0] req1_addr,
  input  logic                    req1_start,
  input  logic                    req1_ready,
  output logic                    req1_valid,
  output logic                    req1_done,
  output logic                    req1_err,
  output logic                    req1_busy,
  output logic signed [WIDTH-1:0] req1_out0,
  output logic signed [WIDTH-1:0] mem_addr,
  output logic                    mem_start,
  output logic                    mem_ready,
  input  logic                    mem_valid,
  input  logic                    mem_done,
  input  logic signed [WIDTH-1:0] mem_out0,
  output logic                    grant
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Result register of one requester.
  typedef struct packed {
    logic             vld;
    logic             err;
    logic [WIDTH-1:0] dat;
  } resp_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  // Requester inputs gathered into index-able form.
  logic [1:0]       start_in;
  logic [1:0]       ready_in;
  logic [WIDTH-1:0] addr_in [2];

  assign start_in   = {req1_start, req0_start};
  assign ready_in   = {req1_ready, req0_ready};
  assign addr_in[0] = req0_addr;
  assign addr_in[1] = req1_addr;

  // The shared unit's done strobe carries nothing beyond mem_valid.
  logic unused_mem_done;
  assign unused_mem_done = mem_done;

  state_e           state_q, state_d;
  logic [1:0]       pend_q, pend_d;
  logic [WIDTH-1:0] addr_q [2];
  logic [WIDTH-1:0] addr_d [2];
  resp_t            resp_q [2];
  resp_t            resp_d [2];
  logic             grant_q, grant_d;
  logic             init_q, init_d;
  logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic             mem_start_q, mem_start_d;
  logic             mem_ready_q, mem_ready_d;
  logic [7:0]       cnt_q, cnt_d;

  logic [1:0]       hs;
  logic             sel;

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    addr_d     = addr_q;
    resp_d     = resp_q;
    // grant reads 0 during reset and becomes 1 on the first edge after it,
    // so requester 0 wins the first tie. No grant can happen on that edge
    // because nothing can be pending yet.
    grant_d    = init_q ? grant_q : 1'b1;
    init_d     = 1'b1;
    mem_addr_d = mem_addr_q;
    cnt_d      = cnt_q;
    hs         = 2'b00;
    sel        = 1'b0;

    case (state_q)
      IDLE: begin
        if (pend_q != 2'b00) begin
          // On a tie, serve the requester that was not granted last time.
          if (pend_q == 2'b11) begin
            sel = ~grant_q;
          end else begin
            sel = pend_q[1];
          end
          grant_d    = sel;
          mem_addr_d = addr_q[sel];
          state_d    = ISSUE;
        end
      end

      ISSUE: begin
        cnt_d   = 8'd0;
        state_d = WAIT;
      end

      WAIT: begin
        if (mem_valid) begin
          resp_d[grant_q].vld = 1'b1;
          resp_d[grant_q].err = 1'b0;
          resp_d[grant_q].dat = mem_out0;
          state_d             = RESP;
        end else if (cnt_q == TIMEOUT_C) begin
          resp_d[grant_q].vld = 1'b1;
          resp_d[grant_q].err = 1'b1;
          resp_d[grant_q].dat = '0;
          state_d             = RESP;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      RESP: begin
        if (ready_in[grant_q]) begin
          hs[grant_q]         = 1'b1;
          resp_d[grant_q].vld = 1'b0;
          resp_d[grant_q].err = 1'b0;
          pend_d[grant_q]     = 1'b0;
          state_d             = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A start is taken when the slot is free, or when it frees on this very
    // edge; that wins over the handshake clearing pend.
    for (int i = 0; i < 2; i++) begin
      if (start_in[i] && (!pend_q[i] || hs[i])) begin
        pend_d[i] = 1'b1;
        addr_d[i] = addr_in[i];
      end
    end

    // Both strobes are decoded from the next state so they leave a flop.
    // mem_ready stays high outside RESP so a stale result is drained and
    // dropped while IDLE or ISSUE.
    mem_start_d = (state_d == ISSUE);
    mem_ready_d = (state_d != RESP);
  end

  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      state_q     <= IDLE;
      pend_q      <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        addr_q[i] <= '0;
        resp_q[i] <= '0;
      end
      grant_q     <= 1'b0;
      init_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_start_q <= 1'b0;
      mem_ready_q <= 1'b0;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      for (int i = 0; i < 2; i++) begin
        addr_q[i] <= addr_d[i];
        resp_q[i] <= resp_d[i];
      end
      grant_q     <= grant_d;
      init_q      <= init_d;
      mem_addr_q  <= mem_addr_d;
      mem_start_q <= mem_start_d;
      mem_ready_q <= mem_ready_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req0_valid = resp_q[0].vld;
  assign req0_done  = resp_q[0].vld;
  assign req0_err   = resp_q[0].err;
  assign req0_out0  = resp_q[0].dat;
  assign req0_busy  = pend_q[0];

  assign req1_valid = resp_q[1].vld;
  assign req1_done  = resp_q[1].vld;
  assign req1_err   = resp_q[1].err;
  assign req1_out0  = resp_q[1].dat;
  assign req1_busy  = pend_q[1];

  assign mem_addr   = mem_addr_q;
  assign mem_start  = mem_start_q;
  assign mem_ready  = mem_ready_q;
  assign grant      = grant_q;

endmodule

// File: tb/tb_get_data_arbiter.sv
// Purpose: self-checking bench for get_data_arbiter with a get_data stand-in returning addr+42069.
// Latency: a transaction-level timing model is compared against every output on each falling edge.
// Backpressure: directed scenarios drive reqN_ready low and high to hold and release results.
module tb_get_data_arbiter;
  localparam int W  = 32;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic signed [W-1:0] req0_addr = '0;
  logic                req0_start = 1'b0;
  logic                req0_ready = 1'b0;
  logic                req0_valid, req0_done, req0_err, req0_busy;
  logic signed [W-1:0] req0_out0;
  logic signed [W-1:0] req1_addr = '0;
  logic                req1_start = 1'b0;
  logic                req1_ready = 1'b0;
  logic                req1_valid, req1_done, req1_err, req1_busy;
  logic signed [W-1:0] req1_out0;
  logic signed [W-1:0] mem_addr;
  logic                mem_start, mem_ready;
  logic                mem_valid = 1'b0;
  logic                mem_done  = 1'b0;
  logic signed [W-1:0] mem_out0  = '0;
  logic                grant;

  bit hang = 1'b0;   // get_data stand-in never answers while set

  int tests = 0;
  int fails = 0;

  get_data_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    ._clock    (clk),
    ._reset    (rst),
    .req0_addr (req0_addr),
    .req0_start(req0_start),
    .req0_ready(req0_ready),
    .req0_valid(req0_valid),
    .req0_done (req0_done),
    .req0_err  (req0_err),
    .req0_busy (req0_busy),
    .req0_out0 (req0_out0),
    .req1_addr (req1_addr),
    .req1_start(req1_start),
    .req1_ready(req1_ready),
    .req1_valid(req1_valid),
    .req1_done (req1_done),
    .req1_err  (req1_err),
    .req1_busy (req1_busy),
    .req1_out0 (req1_out0),
    .mem_addr  (mem_addr),
    .mem_start (mem_start),
    .mem_ready (mem_ready),
    .mem_valid (mem_valid),
    .mem_done  (mem_done),
    .mem_out0  (mem_out0),
    .grant     (grant)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // get_data stand-in: answers one cycle after seeing mem_start, holds the
  // result until mem_ready takes it. It is not reset, so an answer in
  // flight survives a reset of the arbiter.
  logic                s_start, s_ready, s_valid;
  logic signed [W-1:0] s_addr;
  initial forever begin
    @(posedge clk);
    s_start = mem_start;
    s_ready = mem_ready;
    s_valid = mem_valid;
    s_addr  = mem_addr;
    #1;
    if (s_valid && s_ready) mem_valid = 1'b0;
    if (s_start && !hang) begin
      mem_valid = 1'b1;
      mem_out0  = s_addr + 32'sd42069;
    end
  end

  // Transaction model: one service at a time, tracked by the edge numbers
  // on which it starts and on which its result becomes visible.
  int                  m_cyc = 0;
  bit                  m_seen;
  bit                  m_pend [2];
  logic signed [W-1:0] m_addr [2];
  int                  m_owner;
  int                  m_val_edge;
  int                  m_start_edge;
  int                  m_free_from;
  bit                  m_err;
  logic signed [W-1:0] m_res;
  logic signed [W-1:0] m_maddr;
  bit                  m_grant;

  task automatic model_step();
    bit vb, hs0, hs1, p0, p1;
    int pick;
    if (rst) begin
      m_seen = 1'b0; m_pend[0] = 1'b0; m_pend[1] = 1'b0;
      m_addr[0] = '0; m_addr[1] = '0;
      m_owner = -1; m_val_edge = 0; m_start_edge = -100; m_free_from = 0;
      m_err = 1'b0; m_res = '0; m_maddr = '0; m_grant = 1'b1;
      return;
    end
    m_cyc++;
    m_seen = 1'b1;
    vb  = (m_owner >= 0) && (m_val_edge < m_cyc);
    hs0 = vb && (m_owner == 0) && req0_ready;
    hs1 = vb && (m_owner == 1) && req1_ready;
    p0  = m_pend[0];
    p1  = m_pend[1];
    if (hs0 || hs1) begin
      m_owner     = -1;
      m_free_from = m_cyc + 1;
    end else if (m_owner < 0 && m_cyc >= m_free_from && (p0 || p1)) begin
      if (p0 && p1) pick = m_grant ? 0 : 1;
      else          pick = p0 ? 0 : 1;
      m_owner      = pick;
      m_grant      = (pick == 1);
      m_maddr      = m_addr[pick];
      m_start_edge = m_cyc;
      if (hang) begin
        m_val_edge = m_cyc + TO + 2;
        m_err      = 1'b1;
        m_res      = '0;
      end else begin
        m_val_edge = m_cyc + 2;
        m_err      = 1'b0;
        m_res      = m_addr[pick] + 32'sd42069;
      end
    end
    if (req0_start && (!p0 || hs0)) begin
      m_pend[0] = 1'b1; m_addr[0] = req0_addr;
    end else if (hs0) m_pend[0] = 1'b0;
    if (req1_start && (!p1 || hs1)) begin
      m_pend[1] = 1'b1; m_addr[1] = req1_addr;
    end else if (hs1) m_pend[1] = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison against the model.
  initial forever begin
    bit ev0, ev1, up;
    @(negedge clk);
    up  = !rst && m_seen;
    ev0 = !rst && (m_owner == 0) && (m_val_edge <= m_cyc);
    ev1 = !rst && (m_owner == 1) && (m_val_edge <= m_cyc);
    check("r0_valid", W'(req0_valid), W'(ev0));
    check("r0_done",  W'(req0_done),  W'(ev0));
    check("r0_busy",  W'(req0_busy),  W'(!rst && m_pend[0]));
    if (ev0) begin
      check("r0_err",  W'(req0_err), W'(m_err));
      check("r0_out0", req0_out0, m_res);
    end
    check("r1_valid", W'(req1_valid), W'(ev1));
    check("r1_done",  W'(req1_done),  W'(ev1));
    check("r1_busy",  W'(req1_busy),  W'(!rst && m_pend[1]));
    if (ev1) begin
      check("r1_err",  W'(req1_err), W'(m_err));
      check("r1_out0", req1_out0, m_res);
    end
    check("mem_start", W'(mem_start), W'(up && (m_cyc == m_start_edge)));
    check("mem_addr",  mem_addr, rst ? '0 : m_maddr);
    check("mem_ready", W'(mem_ready),
          W'(up && !((m_owner >= 0) && (m_val_edge <= m_cyc))));
    check("grant",     W'(grant), W'(up && m_grant));
  end

  task automatic wait_valid(input int which, input int maxc, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if ((which == 0) ? req0_valid : req1_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check(name, W'(ok), W'(1'b1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    // Reset values and first cycle out of reset.
    check("rst_grant", W'(grant), 0);
    check("rst_mem_ready", W'(mem_ready), 0);
    tick();
    check("post_rst_grant", W'(grant), 1);
    check("post_rst_mem_ready", W'(mem_ready), 1);

    // Simultaneous starts after reset: requester 0 wins the tie.
    req0_addr = 1; req1_addr = 2; req0_ready = 1'b1; req1_ready = 1'b1;
    req0_start = 1'b1; req1_start = 1'b1;
    tick();
    req0_start = 1'b0; req1_start = 1'b0;
    wait_valid(0, 10, "tie_a_r0_seen");
    check("tie_a_r1_not_first", W'(req1_valid), 0);
    check("tie_a_r0_out", req0_out0, 42070);
    tick();
    wait_valid(1, 10, "tie_a_r1_seen");
    check("tie_a_r1_out", req1_out0, 42071);
    tick();
    req0_ready = 1'b0; req1_ready = 1'b0;
    tick();

    // Single request: latency and hold under backpressure.
    req0_addr = 100; req0_start = 1'b1;
    tick();
    req0_start = 1'b0;
    tick();
    check("single_mem_start", W'(mem_start), 1);
    check("single_mem_addr", mem_addr, 100);
    tick();
    check("single_not_yet", W'(req0_valid), 0);
    tick();
    check("single_valid", W'(req0_valid), 1);
    check("single_out", req0_out0, 42169);
    check("single_err", W'(req0_err), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("single_hold_valid", W'(req0_valid), 1);
      check("single_hold_out", req0_out0, 42169);
    end
    req0_ready = 1'b1;
    tick();
    req0_ready = 1'b0;
    check("single_released", W'(req0_valid), 0);
    check("single_busy_clear", W'(req0_busy), 0);
    tick();

    // Repeated tie with grant now at 0: requester 1 goes first.
    req0_addr = 1; req1_addr = 2; req0_ready = 1'b1; req1_ready = 1'b1;
    req0_start = 1'b1; req1_start = 1'b1;
    tick();
    req0_start = 1'b0; req1_start = 1'b0;
    wait_valid(1, 10, "tie_b_r1_seen");
    check("tie_b_r0_not_first", W'(req0_valid), 0);
    check("tie_b_r1_out", req1_out0, 42071);
    tick();
    wait_valid(0, 10, "tie_b_r0_seen");
    check("tie_b_r0_out", req0_out0, 42070);
    tick();
    req0_ready = 1'b0; req1_ready = 1'b0;
    tick();

    // Start while pending is dropped.
    req1_addr = 5; req1_start = 1'b1;
    tick();
    req1_start = 1'b0;
    tick();
    req1_addr = 9; req1_start = 1'b1;
    tick();
    req1_start = 1'b0;
    wait_valid(1, 10, "pend_r1_seen");
    check("pend_r1_out", req1_out0, 42074);
    check("pend_busy", W'(req1_busy), 1);
    req1_ready = 1'b1;
    tick();
    req1_ready = 1'b0;
    check("pend_busy_clear", W'(req1_busy), 0);
    repeat (6) tick();

    // Timeout, then a late answer arriving in IDLE.
    hang = 1'b1;
    req0_addr = 33; req0_start = 1'b1;
    tick();
    req0_start = 1'b0;
    repeat (17) tick();
    check("to_not_yet", W'(req0_valid), 0);
    tick();
    check("to_valid", W'(req0_valid), 1);
    check("to_err", W'(req0_err), 1);
    check("to_out", req0_out0, 0);
    req0_ready = 1'b1;
    tick();
    req0_ready = 1'b0;
    hang = 1'b0;
    mem_valid = 1'b1; mem_out0 = 12345;
    tick();
    mem_valid = 1'b0;
    repeat (4) tick();
    check("late_ignored", W'(req0_valid), 0);

    // Handshake and a new start on the same edge.
    req0_addr = 50; req0_start = 1'b1;
    tick();
    req0_start = 1'b0;
    wait_valid(0, 10, "hs_first_seen");
    check("hs_first_out", req0_out0, 42119);
    req0_ready = 1'b1; req0_start = 1'b1; req0_addr = 7;
    tick();
    req0_ready = 1'b0; req0_start = 1'b0;
    check("hs_valid_cleared", W'(req0_valid), 0);
    check("hs_busy_kept", W'(req0_busy), 1);
    tick();
    tick();
    check("hs_second_not_yet", W'(req0_valid), 0);
    tick();
    check("hs_second_valid", W'(req0_valid), 1);
    check("hs_second_out", req0_out0, 42076);
    req0_ready = 1'b1;
    tick();
    req0_ready = 1'b0;
    tick();

    // Asynchronous reset in the middle of WAIT.
    req1_addr = 3; req1_start = 1'b1;
    tick();
    req1_start = 1'b0;
    tick();
    tick();
    check("mid_wait_busy", W'(req1_busy), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_all_zero",
          W'(|{req0_valid, req0_done, req0_err, req0_busy, req0_out0,
               req1_valid, req1_done, req1_err, req1_busy, req1_out0,
               mem_addr, mem_start, mem_ready, grant}), 0);
    tick();
    rst = 1'b0;
    tick();
    check("rerst_grant", W'(grant), 1);
    check("rerst_mem_ready", W'(mem_ready), 1);
    check("rerst_busy", W'(req1_busy), 0);
    repeat (6) tick();
    check("stale_ignored", W'(req1_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
